cardinal_nic_buffered: RTL and testbench

Parametrised successor to the single-entry cardinal NIC: the processor/ring interface block, one per node in the CMP.
- Replaces the one-packet input/output buffers with configurable-depth FIFOs.
- Exposes occupancy counts and a drop counter through the status registers.
- Gates injection on ring polarity against the packet VC bit.
- Sits between cardinal_processor (nicEn/nicWrEn/addr/d_in/d_out) and gold_ring (net_* signals).

---
 rtl/cardinal_nic_buffered.sv | 211 +++++++++++++++++++++
 tb/tb_cardinal_nic_buffered.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/cardinal_nic_buffered.sv
`default_nettype none
// ============================================================================
// Module      : cardinal_nic_buffered
// Description : Processor/ring network interface for one CMP node. It holds
//               an input FIFO (ring -> processor) and an output FIFO
//               (processor -> ring) of configurable depth. Occupancy and a
//               saturating drop counter are exposed as status registers.
//               Injection onto the ring waits until the ring polarity matches
//               the virtual-channel bit of the head packet.
// Revision    : 1.0 - initial buffered release
// ----------------------------------------------------------------------------
// Ports
//   clk          in   1    clock, rising edge
//   reset        in   1    synchronous active-high reset
//   addr         in   2    00 in-data, 01 in-status, 10 out-data, 11 out-status
//   d_in         in   DW   processor write data
//   d_out        out  DW   processor read data (combinational)
//   nicEn        in   1    register access enable
//   nicWrEn      in   1    1 = write, 0 = read
//   net_si       in   1    ring offers a packet
//   net_ri       out  1    NIC can accept a packet
//   net_di       in   DW   packet from ring
//   net_so       out  1    NIC sends a packet
//   net_ro       in   1    ring can accept a packet
//   net_do       out  DW   packet to ring
//   net_polarity in   1    ring cycle polarity
// Packets use big-endian bit numbering: bit 0 is the most significant bit.
// ============================================================================
module cardinal_nic_buffered #(
  parameter int DATA_WIDTH = 64,
  parameter int IN_DEPTH   = 4,
  parameter int OUT_DEPTH  = 4,
  parameter int VC_BIT     = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            addr,
  input  logic [0:DATA_WIDTH-1] d_in,
  output logic [0:DATA_WIDTH-1] d_out,
  input  logic                  nicEn,
  input  logic                  nicWrEn,
  input  logic                  net_si,
  output logic                  net_ri,
  input  logic [0:DATA_WIDTH-1] net_di,
  output logic                  net_so,
  input  logic                  net_ro,
  output logic [0:DATA_WIDTH-1] net_do,
  input  logic                  net_polarity
);

  localparam int IN_AW  = $clog2(IN_DEPTH);
  localparam int OUT_AW = $clog2(OUT_DEPTH);
  // Internal vectors are little-endian numbered, so the big-endian VC bit
  // index has to be mirrored.
  localparam int VC_IDX = DATA_WIDTH - 1 - VC_BIT;

  localparam logic [1:0] ADDR_IN_DATA  = 2'b00;
  localparam logic [1:0] ADDR_IN_STAT  = 2'b01;
  localparam logic [1:0] ADDR_OUT_DATA = 2'b10;
  localparam logic [1:0] ADDR_OUT_STAT = 2'b11;

  localparam logic [IN_AW:0]    IN_CNT_ONE   = 1;
  localparam logic [IN_AW:0]    IN_CNT_FULL  = IN_DEPTH[IN_AW:0];
  localparam logic [IN_AW-1:0]  IN_PTR_ONE   = 1;
  localparam logic [OUT_AW:0]   OUT_CNT_ONE  = 1;
  localparam logic [OUT_AW:0]   OUT_CNT_FULL = OUT_DEPTH[OUT_AW:0];
  localparam logic [OUT_AW-1:0] OUT_PTR_ONE  = 1;

  // Port data re-expressed little-endian; a vector assignment copies by
  // position, so numeric values are unchanged.
  logic [DATA_WIDTH-1:0] w_d_in;
  logic [DATA_WIDTH-1:0] w_net_di;
  assign w_d_in   = d_in;
  assign w_net_di = net_di;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] in_mem_q  [IN_DEPTH];
  logic [DATA_WIDTH-1:0] out_mem_q [OUT_DEPTH];

  logic [IN_AW-1:0]  in_rd_q,  in_rd_d,  in_wr_q,  in_wr_d;
  logic [IN_AW:0]    in_cnt_q, in_cnt_d;
  logic [OUT_AW-1:0] out_rd_q, out_rd_d, out_wr_q, out_wr_d;
  logic [OUT_AW:0]   out_cnt_q, out_cnt_d;
  logic [7:0]        drop_cnt_q, drop_cnt_d;

  // --------------------------------------------------------------------------
  // Handshakes, all decided from pre-edge occupancy
  // --------------------------------------------------------------------------
  logic w_in_empty, w_in_full, w_out_empty, w_out_full;
  logic w_rd, w_wr;
  logic w_in_push, w_in_pop, w_out_push, w_out_pop, w_drop;
  logic [DATA_WIDTH-1:0] w_in_head, w_out_head;

  assign w_in_empty  = (in_cnt_q == '0);
  assign w_in_full   = (in_cnt_q == IN_CNT_FULL);
  assign w_out_empty = (out_cnt_q == '0);
  assign w_out_full  = (out_cnt_q == OUT_CNT_FULL);

  assign w_in_head  = in_mem_q[in_rd_q];
  assign w_out_head = out_mem_q[out_rd_q];

  assign w_rd = nicEn && !nicWrEn;
  assign w_wr = nicEn && nicWrEn;

  assign net_ri = !reset && !w_in_full;
  // A mismatched polarity stalls the head in place; later packets wait behind.
  assign net_so = !reset && !w_out_empty && net_ro &&
                  (w_out_head[VC_IDX] == net_polarity);
  assign net_do = (!reset && !w_out_empty) ? w_out_head : '0;

  assign w_in_push  = net_si && net_ri;
  assign w_in_pop   = !reset && w_rd && (addr == ADDR_IN_DATA) && !w_in_empty;
  assign w_out_push = !reset && w_wr && (addr == ADDR_OUT_DATA) && !w_out_full;
  assign w_drop     = !reset && w_wr && (addr == ADDR_OUT_DATA) && w_out_full;
  assign w_out_pop  = net_so;

  // --------------------------------------------------------------------------
  // Processor read path
  // --------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] w_in_status, w_out_status, w_d_out;

  always_comb begin
    w_in_status       = '0;
    w_in_status[0]    = !w_in_empty;
    w_in_status[8:1]  = 8'(in_cnt_q);
    w_out_status      = '0;
    w_out_status[0]   = w_out_full;
    w_out_status[8:1] = 8'(out_cnt_q);
    w_out_status[16:9] = drop_cnt_q;
  end

  always_comb begin
    w_d_out = '0;
    if (!reset && w_rd) begin
      case (addr)
        ADDR_IN_DATA:  if (!w_in_empty) w_d_out = w_in_head;
        ADDR_IN_STAT:  w_d_out = w_in_status;
        ADDR_OUT_STAT: w_d_out = w_out_status;
        default:       w_d_out = '0;
      endcase
    end
  end

  assign d_out = w_d_out;

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    in_rd_d  = in_rd_q;
    in_wr_d  = in_wr_q;
    in_cnt_d = in_cnt_q;
    if (w_in_push) in_wr_d = in_wr_q + IN_PTR_ONE;
    if (w_in_pop)  in_rd_d = in_rd_q + IN_PTR_ONE;
    case ({w_in_push, w_in_pop})
      2'b10:   in_cnt_d = in_cnt_q + IN_CNT_ONE;
      2'b01:   in_cnt_d = in_cnt_q - IN_CNT_ONE;
      default: in_cnt_d = in_cnt_q;
    endcase
  end

  always_comb begin
    out_rd_d   = out_rd_q;
    out_wr_d   = out_wr_q;
    out_cnt_d  = out_cnt_q;
    drop_cnt_d = drop_cnt_q;
    if (w_out_push) out_wr_d = out_wr_q + OUT_PTR_ONE;
    if (w_out_pop)  out_rd_d = out_rd_q + OUT_PTR_ONE;
    case ({w_out_push, w_out_pop})
      2'b10:   out_cnt_d = out_cnt_q + OUT_CNT_ONE;
      2'b01:   out_cnt_d = out_cnt_q - OUT_CNT_ONE;
      default: out_cnt_d = out_cnt_q;
    endcase
    // Saturates so software can still tell "many drops" from "none".
    if (w_drop && (drop_cnt_q != 8'hFF)) drop_cnt_d = drop_cnt_q + 8'd1;
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      in_rd_q    <= '0;
      in_wr_q    <= '0;
      in_cnt_q   <= '0;
      out_rd_q   <= '0;
      out_wr_q   <= '0;
      out_cnt_q  <= '0;
      drop_cnt_q <= '0;
    end else begin
      in_rd_q    <= in_rd_d;
      in_wr_q    <= in_wr_d;
      in_cnt_q   <= in_cnt_d;
      out_rd_q   <= out_rd_d;
      out_wr_q   <= out_wr_d;
      out_cnt_q  <= out_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // Storage needs no reset: entries are only visible between push and pop,
  // and both push enables are already suppressed while reset is high.
  always_ff @(posedge clk) begin
    if (w_in_push)  in_mem_q[in_wr_q]   <= w_net_di;
    if (w_out_push) out_mem_q[out_wr_q] <= w_d_in;
  end

endmodule
`default_nettype wire

// File: tb/tb_cardinal_nic_buffered.sv
`default_nettype none
// ============================================================================
// Module      : tb_cardinal_nic_buffered
// Description : Directed plus randomized bench for cardinal_nic_buffered with
//               a queue-based reference model of both FIFOs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cardinal_nic_buffered;

  localparam int DW  = 64;
  localparam int ID  = 4;
  localparam int OD  = 4;
  localparam int VCI = DW - 1;  // VC bit 0 (big-endian) is the numeric MSB

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic [1:0]    addr;
  logic [DW-1:0] d_in, d_out, net_di, net_do;
  logic          nicEn, nicWrEn, net_si, net_ri, net_so, net_ro, net_polarity;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [DW-1:0] inq[$];
  logic [DW-1:0] outq[$];
  int            drop = 0;

  cardinal_nic_buffered #(
    .DATA_WIDTH(DW), .IN_DEPTH(ID), .OUT_DEPTH(OD), .VC_BIT(0)
  ) dut (
    .clk(clk), .reset(reset), .addr(addr), .d_in(d_in), .d_out(d_out),
    .nicEn(nicEn), .nicWrEn(nicWrEn), .net_si(net_si), .net_ri(net_ri),
    .net_di(net_di), .net_so(net_so), .net_ro(net_ro), .net_do(net_do),
    .net_polarity(net_polarity)
  );

  task automatic chk(input string tag, input logic [DW-1:0] obs,
                     input logic [DW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] mdl_dout();
    if (reset || !nicEn || nicWrEn) return '0;
    case (addr)
      2'd0:    return (inq.size() > 0) ? inq[0] : '0;
      2'd1:    return (DW'(inq.size()) << 1) | DW'(inq.size() != 0);
      2'd3:    return (DW'(drop) << 9) | (DW'(outq.size()) << 1) |
                      DW'(outq.size() == OD);
      default: return '0;
    endcase
  endfunction

  function automatic logic mdl_so();
    if (reset || outq.size() == 0 || !net_ro) return 1'b0;
    return outq[0][VCI] == net_polarity;
  endfunction

  // One clock: check every output against the model, apply the edge to the
  // model, then advance to just after the next rising edge.
  task automatic cyc(input string tag);
    logic so;
    bit   in_full, out_full;
    #1;
    so = mdl_so();
    chk({tag, ".ri"},   DW'(net_ri), DW'(!reset && inq.size() < ID));
    chk({tag, ".so"},   DW'(net_so), DW'(so));
    chk({tag, ".do"},   net_do, (!reset && outq.size() > 0) ? outq[0] : '0);
    chk({tag, ".dout"}, d_out, mdl_dout());
    if (reset) begin
      inq.delete();
      outq.delete();
      drop = 0;
    end else begin
      in_full  = (inq.size() == ID);
      out_full = (outq.size() == OD);
      if (nicEn && !nicWrEn && addr == 2'd0 && inq.size() > 0) void'(inq.pop_front());
      if (net_si && !in_full) inq.push_back(net_di);
      if (so) void'(outq.pop_front());
      if (nicEn && nicWrEn && addr == 2'd2) begin
        if (!out_full) outq.push_back(d_in);
        else if (drop < 255) drop++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    nicEn = 0; nicWrEn = 0; addr = 2'd0; d_in = '0;
    net_si = 0; net_di = '0; net_ro = 0; net_polarity = 0;
  endtask

  function automatic logic [DW-1:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  logic [DW-1:0] pk[5];

  initial begin
    reset = 1;
    idle();

    // Reset and idle
    cyc("rst0");
    cyc("rst1");
    reset = 0;
    #1;
    chk("idle_ri", DW'(net_ri), 64'd1);
    chk("idle_so", DW'(net_so), 64'd0);
    nicEn = 1; addr = 2'd1;
    #1 chk("idle_st_in", d_out, 64'd0);
    cyc("idle_rd01");
    addr = 2'd3;
    #1 chk("idle_st_out", d_out, 64'd0);
    cyc("idle_rd11");

    // Polarity-gated send
    nicWrEn = 1; addr = 2'd2; d_in = 64'h8000_0000_0000_00AA;
    net_ro = 1; net_polarity = 0;
    cyc("wr_aa");
    nicEn = 0; nicWrEn = 0;
    #1 chk("pol0_so", DW'(net_so), 64'd0);
    cyc("pol0");
    net_polarity = 1;
    #1 chk("pol1_so", DW'(net_so), 64'd1);
    chk("pol1_do", net_do, 64'h8000_0000_0000_00AA);
    cyc("pol1");
    nicEn = 1; addr = 2'd3;
    #1 chk("sent_so", DW'(net_so), 64'd0);
    chk("sent_st_out", d_out, 64'd0);
    cyc("sent");
    idle();

    // Fill the input FIFO, overflow attempt, drain in order
    for (int i = 0; i < 5; i++) pk[i] = rnd64();
    net_si = 1;
    for (int i = 0; i < 4; i++) begin
      net_di = pk[i];
      cyc("fill_in");
    end
    net_di = pk[4]; nicEn = 1; addr = 2'd1;
    #1 chk("full_ri", DW'(net_ri), 64'd0);
    chk("full_st_in", d_out, 64'd9);
    cyc("in_overflow");
    net_si = 0; addr = 2'd0;
    for (int i = 0; i < 4; i++) begin
      #1 chk("drain_order", d_out, pk[i]);
      cyc("drain");
    end
    #1 chk("drain_empty", d_out, 64'd0);
    cyc("drain_empty");
    idle();

    // Output FIFO overflow with ring stalled
    nicEn = 1; nicWrEn = 1; addr = 2'd2;
    for (int i = 0; i < 6; i++) begin
      d_in = rnd64();
      cyc("fill_out");
    end
    nicWrEn = 0; addr = 2'd3;
    #1 chk("out_full_st", d_out, 64'h409);
    cyc("out_full_st");
    idle();

    // Simultaneous pop and push on a full input FIFO
    net_si = 1;
    for (int i = 0; i < 4; i++) begin
      net_di = rnd64();
      cyc("refill_in");
    end
    net_di = rnd64(); nicEn = 1; addr = 2'd0;
    #1 chk("popfull_ri", DW'(net_ri), 64'd0);
    cyc("pop_push_full");
    addr = 2'd1;
    #1 chk("after_pop_ri", DW'(net_ri), 64'd1);
    chk("after_pop_cnt3", d_out, 64'd7);
    cyc("push_after_pop");
    net_si = 0;
    #1 chk("refull_cnt4", d_out, 64'd9);
    cyc("refull");

    // Half-fill both FIFOs, then reset
    net_ro = 1; addr = 2'd0;
    for (int i = 0; i < 2; i++) begin
      net_polarity = outq[0][VCI];
      cyc("half");
    end
    net_ro = 0; addr = 2'd1;
    #1 chk("half_st_in", d_out, 64'd5);
    cyc("half_in");
    addr = 2'd3;
    #1 chk("half_st_out", d_out, 64'h404);
    cyc("half_out");
    reset = 1;
    cyc("mid_reset");
    reset = 0; net_ro = 1; addr = 2'd1;
    #1 chk("post_rst_in", d_out, 64'd0);
    chk("post_rst_so", DW'(net_so), 64'd0);
    cyc("post_rst_in");
    addr = 2'd3;
    #1 chk("post_rst_out", d_out, 64'd0);
    cyc("post_rst_out");

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      reset        = ($urandom_range(0, 63) == 0);
      nicEn        = ($urandom_range(0, 3) != 0);
      nicWrEn      = $urandom_range(0, 1);
      addr         = 2'($urandom_range(0, 3));
      d_in         = rnd64();
      net_si       = $urandom_range(0, 1);
      net_di       = rnd64();
      net_ro       = ($urandom_range(0, 3) != 0);
      net_polarity = $urandom_range(0, 1);
      cyc("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
